// File: rtl/tank_boundary_mover.sv
// Per-frame tank position updater: on frame_tick, steps each tank one STEP in its latched
// direction (one tank per cycle), clamping at the field walls and flagging clamped tanks.
module tank_boundary_mover #(
    parameter int unsigned N_TANKS = 4,
    parameter int unsigned W       = 9,
    parameter int unsigned X_MIN   = 0,
    parameter int unsigned X_MAX   = 272,
    parameter int unsigned Y_MIN   = 0,
    parameter int unsigned Y_MAX   = 224,
    parameter int unsigned SIZE    = 16,
    parameter int unsigned STEP    = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   frame_tick_i,
    input  logic [N_TANKS-1:0]     move_valid_i,
    input  logic [2*N_TANKS-1:0]   move_dir_i,
    input  logic                   load_i,
    input  logic [3:0]             load_id_i,
    input  logic [W-1:0]           load_x_i,
    input  logic [W-1:0]           load_y_i,
    output logic [W*N_TANKS-1:0]   tank_x_o,
    output logic [W*N_TANKS-1:0]   tank_y_o,
    output logic [N_TANKS-1:0]     collide_o,
    output logic                   busy_o,
    output logic                   update_done_o,
    output logic                   overrun_o
);

    // One extra bit so wall tests never wrap around.
    localparam logic [W:0] XMinE = (W+1)'(X_MIN);
    localparam logic [W:0] YMinE = (W+1)'(Y_MIN);
    localparam logic [W:0] XMaxE = (W+1)'(X_MAX);
    localparam logic [W:0] YMaxE = (W+1)'(Y_MAX);
    localparam logic [W:0] XHiE  = (W+1)'(X_MAX - SIZE);
    localparam logic [W:0] YHiE  = (W+1)'(Y_MAX - SIZE);
    localparam logic [W:0] SizeE = (W+1)'(SIZE);
    localparam logic [W:0] StepE = (W+1)'(STEP);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e               state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    logic [W-1:0]         pos_x_q [N_TANKS];
    logic [W-1:0]         pos_x_d [N_TANKS];
    logic [W-1:0]         pos_y_q [N_TANKS];
    logic [W-1:0]         pos_y_d [N_TANKS];
    logic [N_TANKS-1:0]   col_q, col_d;
    logic [N_TANKS-1:0]   valid_q, valid_d;
    logic [2*N_TANKS-1:0] dir_q, dir_d;
    logic                 overrun_q, overrun_d;

    logic [W-1:0] cur_x, cur_y;
    logic         cur_v;
    logic [1:0]   cur_dir;
    logic [W:0]   nx_e, ny_e;
    logic         mv_col;

    logic [W:0]   lx_e, ly_e;
    logic [W-1:0] ld_x, ld_y;
    logic         ld_col;

    // Move of the tank currently selected by idx_q.
    always_comb begin
        cur_x   = '0;
        cur_y   = '0;
        cur_v   = 1'b0;
        cur_dir = 2'd0;
        for (int i = 0; i < N_TANKS; i++) begin
            if (idx_q == 4'(i)) begin
                cur_x   = pos_x_q[i];
                cur_y   = pos_y_q[i];
                cur_v   = valid_q[i];
                cur_dir = dir_q[2*i +: 2];
            end
        end
        nx_e   = {1'b0, cur_x};
        ny_e   = {1'b0, cur_y};
        mv_col = 1'b0;
        if (cur_v) begin
            unique case (cur_dir)
                2'd0: begin
                    if ({1'b0, cur_y} < YMinE + StepE) begin
                        ny_e   = YMinE;
                        mv_col = 1'b1;
                    end else begin
                        ny_e = {1'b0, cur_y} - StepE;
                    end
                end
                2'd1: begin
                    if ({1'b0, cur_x} + SizeE + StepE > XMaxE) begin
                        nx_e   = XHiE;
                        mv_col = 1'b1;
                    end else begin
                        nx_e = {1'b0, cur_x} + StepE;
                    end
                end
                2'd2: begin
                    if ({1'b0, cur_y} + SizeE + StepE > YMaxE) begin
                        ny_e   = YHiE;
                        mv_col = 1'b1;
                    end else begin
                        ny_e = {1'b0, cur_y} + StepE;
                    end
                end
                2'd3: begin
                    if ({1'b0, cur_x} < XMinE + StepE) begin
                        nx_e   = XMinE;
                        mv_col = 1'b1;
                    end else begin
                        nx_e = {1'b0, cur_x} - StepE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Load position clamped into the legal window on each axis.
    always_comb begin
        lx_e   = {1'b0, load_x_i};
        ly_e   = {1'b0, load_y_i};
        ld_x   = load_x_i;
        ld_y   = load_y_i;
        ld_col = 1'b0;
        if (XMinE > lx_e) begin
            ld_x   = XMinE[W-1:0];
            ld_col = 1'b1;
        end else if (lx_e > XHiE) begin
            ld_x   = XHiE[W-1:0];
            ld_col = 1'b1;
        end
        if (YMinE > ly_e) begin
            ld_y   = YMinE[W-1:0];
            ld_col = 1'b1;
        end else if (ly_e > YHiE) begin
            ld_y   = YHiE[W-1:0];
            ld_col = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        col_d     = col_q;
        valid_d   = valid_q;
        dir_d     = dir_q;
        overrun_d = overrun_q;
        unique case (state_q)
            StIdle: begin
                if (load_i && ({1'b0, load_id_i} < 5'(N_TANKS))) begin
                    for (int i = 0; i < N_TANKS; i++) begin
                        if (load_id_i == 4'(i)) begin
                            pos_x_d[i] = ld_x;
                            pos_y_d[i] = ld_y;
                            col_d[i]   = ld_col;
                        end
                    end
                end
                if (frame_tick_i) begin
                    state_d = StScan;
                    idx_d   = '0;
                    valid_d = move_valid_i;
                    dir_d   = move_dir_i;
                end
            end
            StScan: begin
                for (int i = 0; i < N_TANKS; i++) begin
                    if (idx_q == 4'(i)) begin
                        pos_x_d[i] = nx_e[W-1:0];
                        pos_y_d[i] = ny_e[W-1:0];
                        col_d[i]   = mv_col;
                    end
                end
                if (idx_q == 4'(N_TANKS - 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
                if (frame_tick_i) begin
                    overrun_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                idx_d   = '0;
                if (frame_tick_i) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            col_q     <= '0;
            valid_q   <= '0;
            dir_q     <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < N_TANKS; i++) begin
                pos_x_q[i] <= XMinE[W-1:0];
                pos_y_q[i] <= YMinE[W-1:0];
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            col_q     <= col_d;
            valid_q   <= valid_d;
            dir_q     <= dir_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < N_TANKS; i++) begin
                pos_x_q[i] <= pos_x_d[i];
                pos_y_q[i] <= pos_y_d[i];
            end
        end
    end

    always_comb begin
        tank_x_o = '0;
        tank_y_o = '0;
        for (int i = 0; i < N_TANKS; i++) begin
            tank_x_o[W*i +: W] = pos_x_q[i];
            tank_y_o[W*i +: W] = pos_y_q[i];
        end
    end

    assign collide_o     = col_q;
    assign busy_o        = (state_q != StIdle);
    assign update_done_o = (state_q == StDone);
    assign overrun_o     = overrun_q;

endmodule
